// File: rtl/b9_test_pkg.sv
// Shared definitions for the b9 original/dual-candidate response path:
// response width, compactor FSM states and default MISR constants.
package b9_test_pkg;

   localparam int OUT_W = 21;

   localparam logic [23:0] DEF_POLY = 24'h5D6DCB;
   localparam logic [23:0] DEF_SEED = 24'hFEDCBA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/b9_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial
// feedback, XORing one response word per enabled cycle.
module b9_misr #(
   parameter int               SIG_W = 24,
   parameter logic [SIG_W-1:0] POLY  = b9_test_pkg::DEF_POLY,
   parameter logic [SIG_W-1:0] SEED  = b9_test_pkg::DEF_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [SIG_W-1:0] din,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   // Load of the seed takes priority so a new run always starts clean.
   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = SEED;
      end else if (en) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/b9_resp_compactor.sv
// Compares original and dual-candidate b9 responses per vector, logs the
// first mismatch and compacts the original's responses into a signature.
module b9_resp_compactor #(
   parameter int               OUT_W = b9_test_pkg::OUT_W,
   parameter int               SIG_W = 24,
   parameter logic [SIG_W-1:0] POLY  = b9_test_pkg::DEF_POLY,
   parameter logic [SIG_W-1:0] SEED  = b9_test_pkg::DEF_SEED,
   parameter int               CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OUT_W-1:0] resp_a,
   input  logic [OUT_W-1:0] resp_b,
   input  logic [SIG_W-1:0] golden_sig,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] sig,
   output logic [CNT_W-1:0] vec_cnt,
   output logic             mismatch,
   output logic [CNT_W-1:0] first_mm_idx,
   output logic [OUT_W-1:0] first_mm_diff
);

   import b9_test_pkg::*;

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] cnt_q;
   logic             mm_q;
   logic [CNT_W-1:0] mmIdx_q;
   logic [OUT_W-1:0] mmDiff_q;

   logic             accept;
   logic             misrLoad;

   assign accept   = in_valid && busy_q;
   assign misrLoad = start && !busy_q;

   // busy/done are registered alongside the state so in_ready never
   // depends combinationally on any input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         num_q    <= '0;
         cnt_q    <= '0;
         mm_q     <= 1'b0;
         mmIdx_q  <= '0;
         mmDiff_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  num_q    <= num_vec;
                  cnt_q    <= '0;
                  mm_q     <= 1'b0;
                  mmIdx_q  <= '0;
                  mmDiff_q <= '0;
                  if (num_vec != '0) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end else begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (in_valid) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if ((resp_a != resp_b) && !mm_q) begin
                     mm_q     <= 1'b1;
                     mmIdx_q  <= cnt_q;
                     mmDiff_q <= resp_a ^ resp_b;
                  end
                  if (cnt_q == num_q - CNT_W'(1)) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   b9_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misrLoad),
      .en   (accept),
      .din  (SIG_W'(resp_a)),
      .sig  (sig)
   );

   assign in_ready      = busy_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign vec_cnt       = cnt_q;
   assign mismatch      = mm_q;
   assign first_mm_idx  = mmIdx_q;
   assign first_mm_diff = mmDiff_q;
   assign pass          = done_q && (sig == golden_sig) && !mm_q;

endmodule

// File: tb/tb_b9_resp_compactor.sv
// Directed bench for b9_resp_compactor; a second instance with a zero seed
// shares the stimulus so the zero-seed vector can be checked exactly.
module tb_b9_resp_compactor;

   localparam logic [23:0] SEED = 24'hFEDCBA;
   localparam logic [23:0] POLY = 24'h5D6DCB;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_vec;
   logic        in_valid;
   logic [20:0] resp_a;
   logic [20:0] resp_b;
   logic [23:0] golden_sig;
   logic [23:0] golden0;

   logic        in_ready, busy, done, pass, mismatch;
   logic [23:0] sig;
   logic [15:0] vec_cnt, first_mm_idx;
   logic [20:0] first_mm_diff;

   logic        in_ready0, busy0, done0, pass0, mismatch0;
   logic [23:0] sig0;
   logic [15:0] vec_cnt0, first_mm_idx0;
   logic [20:0] first_mm_diff0;

   int          total = 0;
   int          bad = 0;
   logic [23:0] model;

   always #5 clk = ~clk;

   b9_resp_compactor u_dut (
      .clk (clk), .rst (rst), .start (start), .num_vec (num_vec),
      .in_valid (in_valid), .in_ready (in_ready), .resp_a (resp_a), .resp_b (resp_b),
      .golden_sig (golden_sig), .busy (busy), .done (done), .pass (pass), .sig (sig),
      .vec_cnt (vec_cnt), .mismatch (mismatch), .first_mm_idx (first_mm_idx),
      .first_mm_diff (first_mm_diff)
   );

   b9_resp_compactor #(.SEED (24'h000000)) u_dut0 (
      .clk (clk), .rst (rst), .start (start), .num_vec (num_vec),
      .in_valid (in_valid), .in_ready (in_ready0), .resp_a (resp_a), .resp_b (resp_b),
      .golden_sig (golden0), .busy (busy0), .done (done0), .pass (pass0), .sig (sig0),
      .vec_cnt (vec_cnt0), .mismatch (mismatch0), .first_mm_idx (first_mm_idx0),
      .first_mm_diff (first_mm_diff0)
   );

   function automatic logic [23:0] misr_next(input logic [23:0] s, input logic [20:0] d);
      logic [23:0] r;
      r = {s[22:0], 1'b0};
      if (s[23]) r = r ^ POLY;
      return r ^ {3'b000, d};
   endfunction

   // Stimulus helpers only: they drive one edge and keep the model in step.
   task automatic do_start(input logic [15:0] n);
      start = 1'b1;
      num_vec = n;
      @(posedge clk); #1;
      start = 1'b0;
      model = SEED;
   endtask

   task automatic send(input logic [20:0] a, input logic [20:0] b);
      in_valid = 1'b1;
      resp_a = a;
      resp_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model = misr_next(model, a);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0h exp=0", done); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%0h exp=0", in_ready); end
      total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass got=%0h exp=0", pass); end
      total++; if (sig !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL reset_sig got=%0h exp=fedcba", sig); end
      total++; if (sig0 !== 24'h000000) begin bad++; $display("[TB] FAIL reset_sig0 got=%0h exp=0", sig0); end
      total++; if (vec_cnt !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0h exp=0", vec_cnt); end
      total++; if ({mismatch, first_mm_idx, first_mm_diff} !== '0) begin bad++; $display("[TB] FAIL reset_mm got=%0h/%0h/%0h exp=0", mismatch, first_mm_idx, first_mm_diff); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      golden0 = 24'h000001;
      do_start(16'd1);
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%0h exp=1", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got=%0h exp=1", in_ready); end
      send(21'h000001, 21'h000001);
      total++; if (sig0 !== 24'h000001) begin bad++; $display("[TB] FAIL single_sig0 got=%0h exp=1", sig0); end
      total++; if (done0 !== 1'b1) begin bad++; $display("[TB] FAIL single_done0 got=%0h exp=1", done0); end
      total++; if (mismatch0 !== 1'b0) begin bad++; $display("[TB] FAIL single_mm0 got=%0h exp=0", mismatch0); end
      total++; if (pass0 !== 1'b1) begin bad++; $display("[TB] FAIL single_pass0 got=%0h exp=1", pass0); end
      total++; if (sig !== 24'hA0D4BE) begin bad++; $display("[TB] FAIL single_sig got=%0h exp=a0d4be", sig); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL single_ready_end got=%0h exp=0", in_ready); end
      total++; if (vec_cnt !== 16'd1) begin bad++; $display("[TB] FAIL single_cnt got=%0h exp=1", vec_cnt); end
   endtask

   task automatic test_mismatch();
      do_start(16'd3);
      send(21'h000010, 21'h000010);
      send(21'h0ABCDE, 21'h1ABCDE);
      send(21'h1FFFFF, 21'h1FFFFF);
      golden_sig = model;
      #1;
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL mm_done got=%0h exp=1", done); end
      total++; if (sig !== model) begin bad++; $display("[TB] FAIL mm_sig got=%0h exp=%0h", sig, model); end
      total++; if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL mm_flag got=%0h exp=1", mismatch); end
      total++; if (first_mm_idx !== 16'd1) begin bad++; $display("[TB] FAIL mm_idx got=%0h exp=1", first_mm_idx); end
      total++; if (first_mm_diff !== 21'h100000) begin bad++; $display("[TB] FAIL mm_diff got=%0h exp=100000", first_mm_diff); end
      total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL mm_pass got=%0h exp=0", pass); end
   endtask

   task automatic test_zero();
      do_start(16'd0);
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done got=%0h exp=1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy got=%0h exp=0", busy); end
      total++; if (sig !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL zero_sig got=%0h exp=fedcba", sig); end
      total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL zero_mm_clear got=%0h exp=0", mismatch); end
      total++; if (first_mm_idx !== 16'd0) begin bad++; $display("[TB] FAIL zero_idx_clear got=%0h exp=0", first_mm_idx); end
      in_valid = 1'b1;
      resp_a = 21'h000005;
      resp_b = 21'h000006;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (vec_cnt !== 16'd0) begin bad++; $display("[TB] FAIL zero_cnt got=%0h exp=0", vec_cnt); end
      total++; if (sig !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL zero_sig_hold got=%0h exp=fedcba", sig); end
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done_hold got=%0h exp=1", done); end
   endtask

   task automatic test_toggle();
      logic [20:0] data [4];
      logic [15:0] expCnt;
      data[0] = 21'h12345; data[1] = 21'h0F0F0; data[2] = 21'h1C3A5; data[3] = 21'h00001;
      expCnt = 16'd0;
      do_start(16'd4);
      for (int i = 0; i < 7; i++) begin
         in_valid = (i % 2 == 0);
         resp_a = data[i / 2];
         resp_b = data[i / 2];
         @(posedge clk); #1;
         if (i % 2 == 0) begin
            model = misr_next(model, data[i / 2]);
            expCnt = expCnt + 16'd1;
         end
         total++; if (vec_cnt !== expCnt) begin bad++; $display("[TB] FAIL toggle_cnt%0d got=%0h exp=%0h", i, vec_cnt, expCnt); end
         total++; if (done !== (expCnt == 16'd4)) begin bad++; $display("[TB] FAIL toggle_done%0d got=%0h exp=%0h", i, done, expCnt == 16'd4); end
      end
      in_valid = 1'b0;
      golden_sig = model;
      #1;
      total++; if (sig !== model) begin bad++; $display("[TB] FAIL toggle_sig got=%0h exp=%0h", sig, model); end
      total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL toggle_pass got=%0h exp=1", pass); end
   endtask

   task automatic test_start_in_run();
      logic [23:0] held;
      do_start(16'd3);
      send(21'h0AAAAA, 21'h0AAAAA);
      held = sig;
      start = 1'b1;
      num_vec = 16'd1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (vec_cnt !== 16'd1) begin bad++; $display("[TB] FAIL run_start_cnt got=%0h exp=1", vec_cnt); end
      total++; if (sig !== model) begin bad++; $display("[TB] FAIL run_start_sig got=%0h exp=%0h", sig, model); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL run_start_busy got=%0h exp=1", busy); end
      send(21'h155555, 21'h155555);
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL run_latched_num got=%0h exp=1", busy); end
      send(21'h000003, 21'h000003);
      total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL run_end_done got=%0h exp=1", done); end
      total++; if (vec_cnt !== 16'd3) begin bad++; $display("[TB] FAIL run_end_cnt got=%0h exp=3", vec_cnt); end
      total++; if (sig !== model) begin bad++; $display("[TB] FAIL run_end_sig got=%0h exp=%0h (mid %0h)", sig, model, held); end
   endtask

   task automatic test_reset_abort();
      do_start(16'd5);
      send(21'h000004, 21'h000000);
      send(21'h000100, 21'h000000);
      total++; if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL abort_mm got=%0h exp=1", mismatch); end
      total++; if (first_mm_idx !== 16'd0) begin bad++; $display("[TB] FAIL abort_idx got=%0h exp=0", first_mm_idx); end
      total++; if (first_mm_diff !== 21'h000004) begin bad++; $display("[TB] FAIL abort_diff got=%0h exp=4", first_mm_diff); end
      total++; if (vec_cnt !== 16'd2) begin bad++; $display("[TB] FAIL abort_cnt_pre got=%0h exp=2", vec_cnt); end
      rst = 1'b1;
      in_valid = 1'b1;
      resp_a = 21'h000003;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      total++; if ({busy, done, in_ready} !== 3'b000) begin bad++; $display("[TB] FAIL abort_state got=%0b exp=000", {busy, done, in_ready}); end
      total++; if (sig !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL abort_sig got=%0h exp=fedcba", sig); end
      total++; if (vec_cnt !== 16'd0) begin bad++; $display("[TB] FAIL abort_cnt got=%0h exp=0", vec_cnt); end
      total++; if (mismatch !== 1'b0) begin bad++; $display("[TB] FAIL abort_mm_clear got=%0h exp=0", mismatch); end
      in_valid = 1'b1;
      resp_a = 21'h000007;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (vec_cnt !== 16'd0) begin bad++; $display("[TB] FAIL idle_valid_cnt got=%0h exp=0", vec_cnt); end
      total++; if (sig !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL idle_valid_sig got=%0h exp=fedcba", sig); end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_vec = 16'd0;
      in_valid = 1'b0;
      resp_a = '0;
      resp_b = '0;
      golden_sig = '0;
      golden0 = '0;
      model = SEED;
      test_reset();
      test_single();
      test_mismatch();
      test_zero();
      test_toggle();
      test_start_in_run();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
